// File: rtl/ahb_lite_lfsr_tester_if.sv
// AHB-Lite bus bundle between the LFSR memory tester (master) and the
// memory under test (slave). Clock and reset are not carried here.
interface ahb_lite_lfsr_tester_if;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HBURST;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic        HSEL;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HADDR, HWDATA, HTRANS, HBURST, HSIZE, HWRITE, HSEL,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HWDATA, HTRANS, HBURST, HSIZE, HWRITE, HSEL,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_lite_lfsr_tester.sv
// AHB-Lite memory tester: fills WORD_COUNT words starting at STARTADDR with a
// 32-bit Galois LFSR sequence (x^32+x^22+x^2+x+1), reads them back and counts
// mismatches and error responses. Passes repeat while START stays high, and
// the LFSR sequence continues from one pass to the next.
// Optional first-error capture is enabled by defining
// AHB_LITE_LFSR_TESTER_FIRSTERR_EN; otherwise FIRSTERR_* are tied to zero.
module ahb_lite_lfsr_tester #(
  parameter int unsigned WORD_COUNT = 1024,
  parameter logic [31:0] SEED       = 32'h1
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic                          START,
  input  logic [31:0]                   STARTADDR,
  ahb_lite_lfsr_tester_if.master        bus,
  output logic [31:0]                   ERRCOUNT,
  output logic [7:0]                    PASSCOUNT,
  output logic                          BUSY,
  output logic                          FAIL,
  output logic [31:0]                   FIRSTERR_ADDR,
  output logic [31:0]                   FIRSTERR_DATA
);

  localparam int unsigned      IDXW     = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(WORD_COUNT - 1);
  // Right-shifting Galois feedback mask: bits 31,21,1,0 for x^32,x^22,x^2,x
  localparam logic [31:0]      TAPS     = 32'h8020_0003;
  localparam logic [1:0]       NONSEQ   = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_A,
    WR_D,
    RD_A,
    RD_D
  } stateE;

  stateE           state_q, state_d;
  logic [IDXW-1:0] wordIdx_q, wordIdx_d;
  logic [31:0]     baseAddr_q, baseAddr_d;
  logic [31:0]     lfsr_q, lfsr_d;
  logic [31:0]     snap_q, snap_d;
  logic [31:0]     errCount_q, errCount_d;
  logic [7:0]      passCount_q, passCount_d;
  logic            fail_q, fail_d;

  logic            lastWord;
  logic            wrDone;
  logic            rdDone;
  logic            startPass;
  logic            errHit;
  logic [31:0]     curAddr;
  logic [31:0]     lfsrStep;

  assign lastWord = (wordIdx_q == LAST_IDX);
  assign wrDone   = (state_q == WR_D) && bus.HREADY;
  assign rdDone   = (state_q == RD_D) && bus.HREADY;
  // A new pass begins either from IDLE or straight after the last read
  assign startPass = ((state_q == IDLE) && START) || (rdDone && lastWord && START);
  // Address arithmetic is plain 32-bit, so it wraps past the top of memory
  assign curAddr  = baseAddr_q + (32'(wordIdx_q) << 2);
  assign lfsrStep = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);
  assign errHit   = (rdDone && ((bus.HRDATA != lfsr_q) || bus.HRESP)) ||
                    (wrDone && bus.HRESP);

  // State and datapath registers, all cleared asynchronously
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= IDLE;
      wordIdx_q   <= '0;
      baseAddr_q  <= 32'h0;
      lfsr_q      <= SEED;
      snap_q      <= SEED;
      errCount_q  <= 32'h0;
      passCount_q <= 8'h0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wordIdx_q   <= wordIdx_d;
      baseAddr_q  <= baseAddr_d;
      lfsr_q      <= lfsr_d;
      snap_q      <= snap_d;
      errCount_q  <= errCount_d;
      passCount_q <= passCount_d;
      fail_q      <= fail_d;
    end
  end

  // Next-state logic: every bus-facing step waits for HREADY
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (START)       state_d = WR_A;
      WR_A: if (bus.HREADY)  state_d = WR_D;
      WR_D: if (bus.HREADY)  state_d = lastWord ? RD_A : WR_A;
      RD_A: if (bus.HREADY)  state_d = RD_D;
      RD_D: if (bus.HREADY)  state_d = lastWord ? (START ? WR_A : IDLE) : RD_A;
      default:               state_d = IDLE;
    endcase
  end

  // Datapath: word index, LFSR/snapshot, base address and the counters
  always_comb begin
    wordIdx_d   = wordIdx_q;
    baseAddr_d  = baseAddr_q;
    lfsr_d      = lfsr_q;
    snap_d      = snap_q;
    errCount_d  = errCount_q;
    passCount_d = passCount_q;
    fail_d      = fail_q;

    if (wrDone || rdDone) begin
      lfsr_d    = lfsrStep;
      wordIdx_d = lastWord ? '0 : wordIdx_q + IDXW'(1);
    end

    // Read-back replays exactly the values that this pass wrote
    if (wrDone && lastWord) begin
      lfsr_d = snap_q;
    end

    if (rdDone && lastWord) begin
      passCount_d = passCount_q + 8'd1;
    end

    // Snapshot the value the first write will use, after any advance this cycle
    if (startPass) begin
      baseAddr_d = STARTADDR & 32'hFFFF_FFFC;
      snap_d     = lfsr_d;
    end

    if (errHit) begin
      if (errCount_q != 32'hFFFF_FFFF) begin
        errCount_d = errCount_q + 32'd1;
      end
      fail_d = 1'b1;
    end
  end

  // Bus outputs decoded from the current state only
  always_comb begin
    bus.HTRANS = 2'b00;
    bus.HSEL   = 1'b0;
    bus.HWRITE = 1'b0;
    bus.HADDR  = 32'h0;
    bus.HWDATA = 32'h0;
    bus.HBURST = 3'b000;
    bus.HSIZE  = 3'b010;
    case (state_q)
      WR_A: begin
        bus.HTRANS = NONSEQ;
        bus.HSEL   = 1'b1;
        bus.HWRITE = 1'b1;
        bus.HADDR  = curAddr;
      end
      WR_D: begin
        bus.HADDR  = curAddr;
        bus.HWDATA = lfsr_q;
      end
      RD_A: begin
        bus.HTRANS = NONSEQ;
        bus.HSEL   = 1'b1;
        bus.HADDR  = curAddr;
      end
      RD_D: begin
        bus.HADDR  = curAddr;
      end
      default: begin
      end
    endcase
  end

  assign ERRCOUNT  = errCount_q;
  assign PASSCOUNT = passCount_q;
  assign BUSY      = (state_q != IDLE);
  assign FAIL      = fail_q;

`ifdef AHB_LITE_LFSR_TESTER_FIRSTERR_EN
  logic [31:0] firstErrAddr_q;
  logic [31:0] firstErrData_q;

  // Capture only the first error; fail_q already being set means it was taken
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      firstErrAddr_q <= 32'h0;
      firstErrData_q <= 32'h0;
    end else if (errHit && !fail_q) begin
      firstErrAddr_q <= curAddr;
      firstErrData_q <= bus.HRDATA;
    end
  end

  assign FIRSTERR_ADDR = firstErrAddr_q;
  assign FIRSTERR_DATA = firstErrData_q;
`else
  assign FIRSTERR_ADDR = 32'h0;
  assign FIRSTERR_DATA = 32'h0;
`endif

endmodule

// File: tb/tb_ahb_lite_lfsr_tester.sv
// Bench for ahb_lite_lfsr_tester: a behavioural memory slave doubles as the
// monitor, popping expected transfers queued by the stimulus side.
module tb_ahb_lite_lfsr_tester;

  localparam int          N    = 4;
  localparam logic [31:0] SEED = 32'h1;
  localparam int          POLY_EXP [4] = '{32, 22, 2, 1};

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] data;
  } xferT;

  logic        HCLK;
  logic        HRESET;
  logic        START;
  logic [31:0] STARTADDR;
  logic [31:0] ERRCOUNT;
  logic [7:0]  PASSCOUNT;
  logic        BUSY;
  logic        failOut;
  logic [31:0] FIRSTERR_ADDR;
  logic [31:0] FIRSTERR_DATA;

  ahb_lite_lfsr_tester_if bus ();

  ahb_lite_lfsr_tester #(.WORD_COUNT(N), .SEED(SEED)) dut (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .START         (START),
    .STARTADDR     (STARTADDR),
    .bus           (bus),
    .ERRCOUNT      (ERRCOUNT),
    .PASSCOUNT     (PASSCOUNT),
    .BUSY          (BUSY),
    .FAIL          (failOut),
    .FIRSTERR_ADDR (FIRSTERR_ADDR),
    .FIRSTERR_DATA (FIRSTERR_DATA)
  );

  int          assertCount = 0;
  int          failCount   = 0;
  xferT        expQ [$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] modelLfsr;
  logic [31:0] passData [$];

  // Slave behaviour knobs and data-phase tracking
  int          waitSel = 0;
  bit          corruptEn = 0;
  logic [31:0] corruptAddr = 32'h0;
  bit          respErrEn = 0;
  logic [31:0] respErrAddr = 32'h0;
  bit          dActive = 0, dDone = 0, dFirst = 0, inData = 0, errResp = 0;
  logic [31:0] dAddr = 32'h0;
  logic        dWrite = 1'b0;
  int          dWaits = 0;
  logic [31:0] stabAddr, stabData;
  logic [1:0]  stabTrans;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Galois step built from the polynomial's exponent list
  function automatic logic [31:0] polyStep(input logic [31:0] s);
    logic [31:0] mask;
    mask = 32'h0;
    for (int k = 0; k < 4; k++) mask[POLY_EXP[k]-1] = 1'b1;
    return s[0] ? ((s >> 1) ^ mask) : (s >> 1);
  endfunction

  // Expected transfers of one pass: N writes then N reads of the same values
  task automatic pushPass(input logic [31:0] base);
    logic [31:0] b;
    xferT        t;
    b = base & 32'hFFFF_FFFC;
    passData.delete();
    for (int i = 0; i < N; i++) begin
      passData.push_back(modelLfsr);
      modelLfsr = polyStep(modelLfsr);
    end
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < N; i++) begin
        t.addr  = b + 32'(4 * i);
        t.write = (pass == 0);
        t.data  = passData[i];
        expQ.push_back(t);
      end
    end
  endtask

  // Memory slave and monitor: completes each data phase and scores it
  initial begin : slaveMonitor
    xferT        e;
    logic [31:0] rd;
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = 32'h0;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        dActive = 0; dDone = 0; inData = 0;
        bus.HREADY = 1'b1; bus.HRESP = 1'b0;
      end else begin
        if (dDone) begin
          dActive = 0; dDone = 0;
        end
        if (dActive) begin
          inData = 1;
          if (dFirst) begin
            stabAddr = bus.HADDR; stabData = bus.HWDATA; stabTrans = bus.HTRANS; dFirst = 0;
          end else begin
            checkOutput("waitStableAddrData", {bus.HADDR, bus.HWDATA}, {stabAddr, stabData});
            checkOutput("waitStableTrans", 64'(bus.HTRANS), 64'(stabTrans));
          end
          if (dWaits > 0) begin
            bus.HREADY = 1'b0;
            bus.HRESP  = errResp && (dWaits == 1);
            dWaits--;
          end else begin
            bus.HREADY = 1'b1;
            bus.HRESP  = errResp;
            dDone = 1;
            if (expQ.size() == 0) begin
              assertCount++; failCount++;
              $display("[TB] FAIL unexpectedXfer: got addr %0h write %0b, expected no transfer", dAddr, dWrite);
            end else begin
              e = expQ.pop_front();
              checkOutput("xferAddr", 64'(dAddr), 64'(e.addr));
              checkOutput("xferDir", 64'(dWrite), 64'(e.write));
              if (dWrite) begin
                checkOutput("writeData", 64'(bus.HWDATA), 64'(e.data));
                mem[dAddr] = bus.HWDATA;
              end else begin
                rd = mem.exists(dAddr) ? mem[dAddr] : 32'h0;
                checkOutput("readBack", 64'(rd), 64'(e.data));
                if (corruptEn && dAddr == corruptAddr) rd = rd ^ 32'h1;
                bus.HRDATA = rd;
              end
            end
          end
        end else begin
          inData = 0;
          bus.HREADY = 1'b1;
          bus.HRESP  = 1'b0;
          if (bus.HSEL && bus.HTRANS == 2'b10) begin
            dActive = 1; dFirst = 1;
            dAddr   = bus.HADDR;
            dWrite  = bus.HWRITE;
            dWaits  = (waitSel < 0) ? int'($urandom_range(0, 3)) : waitSel;
            errResp = respErrEn && bus.HWRITE && (bus.HADDR == respErrAddr);
            if (errResp && dWaits == 0) dWaits = 1;
          end
        end
      end
    end
  end

  task automatic checkResetValues();
    checkOutput("rstHtrans", 64'(bus.HTRANS), 0);
    checkOutput("rstHsel", 64'(bus.HSEL), 0);
    checkOutput("rstHwrite", 64'(bus.HWRITE), 0);
    checkOutput("rstHaddr", 64'(bus.HADDR), 0);
    checkOutput("rstHwdata", 64'(bus.HWDATA), 0);
    checkOutput("rstErrCount", 64'(ERRCOUNT), 0);
    checkOutput("rstPassCount", 64'(PASSCOUNT), 0);
    checkOutput("rstFail", 64'(failOut), 0);
    checkOutput("rstBusy", 64'(BUSY), 0);
    checkOutput("rstFirstErr", {FIRSTERR_ADDR, FIRSTERR_DATA}, 0);
  endtask

  task automatic applyReset();
    HRESET = 1'b1;
    START  = 1'b0;
    corruptEn = 0; respErrEn = 0; waitSel = 0;
    expQ.delete();
    mem.delete();
    modelLfsr = SEED;
    repeat (2) @(negedge HCLK);
    #2 HRESET = 1'b0;
  endtask

  // Run nPasses passes: a one-cycle START pulse or START held until the last pass
  task automatic applyStimulus(input logic [31:0] base, input int nPasses, input int waits);
    int  budget;
    bit  done;
    waitSel   = waits;
    STARTADDR = base;
    for (int p = 0; p < nPasses; p++) pushPass(base);
    @(negedge HCLK);
    START = 1'b1;
    budget = nPasses * 2 * N * 8 + 100;
    if (nPasses == 1) begin
      @(negedge HCLK);
      START = 1'b0;
      STARTADDR = $urandom;
    end else begin
      for (int c = 0; c < budget && expQ.size() >= 2 * N; c++) @(negedge HCLK);
      START = 1'b0;
    end
    done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge HCLK);
      #2;
      if (!BUSY && expQ.size() == 0) done = 1;
    end
    if (!done) begin
      assertCount++; failCount++;
      $display("[TB] FAIL passTimeout: got busy %0b with %0d transfers pending, expected idle", BUSY, expQ.size());
    end
  endtask

  task automatic checkResults(input logic [7:0] expPass, input logic [31:0] expErr,
                              input logic [31:0] expFa, input logic [31:0] expFd, input bit checkFd);
    checkOutput("passCount", 64'(PASSCOUNT), 64'(expPass));
    checkOutput("errCount", 64'(ERRCOUNT), 64'(expErr));
    checkOutput("failFlag", 64'(failOut), 64'(expErr != 0));
    checkOutput("busyIdle", 64'(BUSY), 0);
    checkOutput("queueDrained", 64'(expQ.size()), 0);
`ifdef AHB_LITE_LFSR_TESTER_FIRSTERR_EN
    checkOutput("firstErrAddr", 64'(FIRSTERR_ADDR), 64'(expFa));
    if (checkFd) checkOutput("firstErrData", 64'(FIRSTERR_DATA), 64'(expFd));
`else
    checkOutput("firstErrTiedOff", {FIRSTERR_ADDR, FIRSTERR_DATA}, 0);
`endif
  endtask

  initial begin : stimulus
    int          totalPass;
    int          np;
    logic [31:0] base;
    logic [31:0] corrupted;
    bit          found;

    HRESET = 1'b1; START = 1'b0; STARTADDR = 32'h0;
    modelLfsr = SEED;
    repeat (2) @(negedge HCLK);
    #1 checkResetValues();
    applyReset();

    $display("[TB] basic pass at 0x100");
    applyStimulus(32'h100, 1, 0);
    checkResults(8'd1, 32'd0, 32'h0, 32'h0, 0);

    $display("[TB] corrupted read at 0x108");
    applyReset();
    corruptEn = 1; corruptAddr = 32'h108;
    applyStimulus(32'h100, 1, 0);
    corrupted = passData[2] ^ 32'h1;
    checkResults(8'd1, 32'd1, 32'h108, corrupted, 1);

    $display("[TB] three wait states per data phase");
    applyReset();
    applyStimulus(32'h100, 1, 3);
    checkResults(8'd1, 32'd0, 32'h0, 32'h0, 0);

    $display("[TB] address wrap from 0xFFFFFFF8");
    applyReset();
    applyStimulus(32'hFFFF_FFF8, 1, 0);
    checkResults(8'd1, 32'd0, 32'h0, 32'h0, 0);

    $display("[TB] error response on write to 0x104");
    applyReset();
    respErrEn = 1; respErrAddr = 32'h104;
    applyStimulus(32'h100, 1, 1);
    checkResults(8'd1, 32'd1, 32'h104, 32'h0, 0);

    $display("[TB] randomized sessions");
    applyReset();
    totalPass = 0;
    for (int s = 0; s < 4; s++) begin
      base = $urandom;
      np   = int'($urandom_range(1, 3));
      applyStimulus(base, np, -1);
      totalPass += np;
      checkResults(8'(totalPass), 32'd0, 32'h0, 32'h0, 0);
    end

    $display("[TB] 300 back-to-back passes");
    applyReset();
    applyStimulus(32'h2000, 300, 0);
    checkResults(8'd44, 32'd0, 32'h0, 32'h0, 0);

    $display("[TB] reset during read of word 2");
    applyReset();
    pushPass(32'h100);
    STARTADDR = 32'h100;
    @(negedge HCLK);
    START = 1'b1;
    @(negedge HCLK);
    START = 1'b0;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge HCLK);
      #2;
      if (inData && !dWrite && dAddr == 32'h108) found = 1;
    end
    if (!found) begin
      assertCount++; failCount++;
      $display("[TB] FAIL midResetWait: got no read data phase at 108, expected one");
    end
    HRESET = 1'b1;
    #1 checkResetValues();
    expQ.delete();
    mem.delete();
    modelLfsr = SEED;
    @(negedge HCLK);
    #2 HRESET = 1'b0;
    applyStimulus(32'h100, 1, 0);
    checkResults(8'd1, 32'd0, 32'h0, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/ahb_lite_lfsr_tester.md
AHB_LITE_LFSR_TESTER -- requirements
Module: ahb_lite_lfsr_tester

Interface
REQ-001 Parameter WORD_COUNT, default 1024: 32-bit words written and then checked per pass; legal range 1..2^20.
REQ-002 Parameter SEED, default 32'h1: LFSR start value after reset; a value of 0 is illegal.
REQ-003 HCLK input 1: the single clock; all state is updated on its rising edge.
REQ-004 HRESET input 1: asynchronous, active-high reset.
REQ-005 START input 1: level; high enables test passes, low stops the block after the current pass.
REQ-006 STARTADDR input 32: base byte address; bits [1:0] are ignored and treated as 0.
REQ-007 HADDR, HWDATA output 32 each; HTRANS output 2; HBURST, HSIZE output 3 each; HWRITE, HSEL output 1 each: AHB-Lite master signals.
REQ-008 HRDATA input 32, HREADY input 1, HRESP input 1: slave response signals.
REQ-009 ERRCOUNT output 32: saturating count of mismatched read words plus HRESP=1 data phases.
REQ-010 PASSCOUNT output 8: count of completed write+check passes; wraps 255->0.
REQ-011 BUSY, FAIL output 1 each: BUSY is high outside IDLE; FAIL is sticky high once ERRCOUNT>0.
REQ-012 FIRSTERR_ADDR, FIRSTERR_DATA output 32 each: first failing address and the HRDATA value read there (see Configuration).

Function
REQ-013 State machine: IDLE, WR_A, WR_D, RD_A, RD_D.
- Transitions: IDLE->WR_A on START=1; WR_A->WR_D on HREADY; WR_D->WR_A on HREADY if words remain; WR_D->RD_A on HREADY after the last word.
- RD_A->RD_D on HREADY; RD_D->RD_A on HREADY if words remain; RD_D->WR_A (START=1) or IDLE (START=0) on HREADY after the last word.
REQ-014 Transfers are single and non-pipelined.
- WR_A/RD_A: HTRANS=2'b10 (NONSEQ), HSEL=1, HBURST=3'b000, HSIZE=3'b010, HWRITE=1 in WR_A and 0 in RD_A.
- All other states: HTRANS=2'b00 and HSEL=0.
REQ-015 HWDATA is valid throughout WR_D and equals the current LFSR value.
REQ-016 Address of word i is STARTADDR+4*i, computed modulo 2^32, so it wraps past 32'hFFFFFFFC to 0.
REQ-017 STARTADDR is sampled on entry to WR_A for word 0 and held for the whole pass.
REQ-018 LFSR is 32-bit Galois, polynomial x^32+x^22+x^2+x+1.
- Advances once per completed WR_D and once per completed RD_D.
REQ-019 On entry to WR_A for word 0, the LFSR value is saved into SNAP; on entry to RD_A for word 0, the LFSR is reloaded from SNAP.
REQ-020 A RD_D cycle with HREADY=1 is an error if HRDATA != LFSR or HRESP=1.
- Each error increments ERRCOUNT by 1, saturating at 32'hFFFFFFFF.
- An error also counts when HRESP=1 in WR_D.
REQ-021 While HREADY=0, all outputs and the state are held.
REQ-022 PASSCOUNT increments on the HREADY cycle of the last RD_D.
REQ-023 START falling mid-pass has no effect until the pass ends.

Reset
REQ-024 HRESET=1 forces, immediately and without a clock:
- state IDLE; HTRANS=0, HSEL=0, HWRITE=0; HADDR=0, HWDATA=0;
- LFSR=SEED, SNAP=SEED; ERRCOUNT=0, PASSCOUNT=0; FAIL=0, BUSY=0; FIRSTERR_ADDR=0, FIRSTERR_DATA=0.
REQ-025 Reset mid-transfer abandons the transfer; no counter update occurs for that transfer.

Configuration
REQ-026 Macro AHB_LITE_LFSR_TESTER_FIRSTERR_EN.
- Defined: on the first error after reset, FIRSTERR_ADDR and FIRSTERR_DATA capture that data phase's address and HRDATA, then hold until the next reset.
- Undefined: both outputs are constant 0 and no capture registers exist.

Verification
REQ-027 WORD_COUNT=4, STARTADDR=32'h100, ideal zero-wait slave, START pulsed high for 1 cycle -> writes to 100/104/108/10C, reads the same addresses, PASSCOUNT=1, ERRCOUNT=0, back in IDLE.
REQ-028 As REQ-027, but the slave corrupts bit 0 of the read at 32'h108 -> ERRCOUNT=1, FAIL=1; with the macro defined, FIRSTERR_ADDR=32'h108 and FIRSTERR_DATA is the corrupted value.
REQ-029 Slave inserts 3 wait states per data phase -> HADDR, HTRANS and HWDATA are stable during the waits; the result matches REQ-027.
REQ-030 STARTADDR=32'hFFFFFFF8, WORD_COUNT=4 -> addresses FFFFFFF8, FFFFFFFC, 0, 4.
REQ-031 START held high for 300 passes with an ideal slave -> PASSCOUNT wraps to 44; read data matches each pass, with the sequence continuing across passes.
REQ-032 HRESET asserted during RD_D of word 2 -> all outputs are at reset values in the same cycle; the next START restarts the writes from STARTADDR with LFSR=SEED.
